cpu_program_loader: RTL and testbench
=====================================

CPU_PROGRAM_LOADER -- requirements
Module: cpu_program_loader

Interface
REQ-001 SHALL have parameter WORDS, default 16, number of RAM words loaded per session (1..16).
REQ-002 SHALL have parameter HOLD, default 4, cycles each address/data phase is held on the bus (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  begin load session; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel session from any non-IDLE state.
REQ-007 SHALL have port byte_in  input  8  next program byte from host source.
REQ-008 SHALL have port byte_valid  input  1  byte_in valid.
REQ-009 SHALL have port byte_ready  output  1  loader accepts byte_in this cycle.
REQ-010 SHALL have port bus_data  output  8  value driven toward the CPU ui_in pins.
REQ-011 SHALL have port bus_load  output  1  load strobe toward CPU uio_in[0]; high = bus_data owns CPU bus.
REQ-012 SHALL have port cpu_rst_n  output  1  holds CPU in reset while loading (low = held).
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on successful session end.
REQ-015 SHALL have port word_idx  output  4  address of word currently being loaded.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_BYTE, DRIVE_ADDR, DRIVE_DATA, GAP, FINISH; all outputs Moore (decoded from registered state/counters only).
REQ-017 IDLE: start=1 -> WAIT_BYTE next cycle, word_idx cleared to 0; start=0 -> stay.
REQ-018 WAIT_BYTE: byte_ready=1 (only state where it is 1); byte_valid=1 latches byte_in into data register and -> DRIVE_ADDR; else stay indefinitely.
REQ-019 DRIVE_ADDR: bus_load=1, bus_data={4'b0000, word_idx}, exactly HOLD cycles, then -> DRIVE_DATA.
REQ-020 DRIVE_DATA: bus_load=1, bus_data=latched byte, exactly HOLD cycles, then -> GAP.
REQ-021 GAP: bus_load=0, bus_data=0 for exactly 1 cycle; then word_idx==WORDS-1 -> FINISH, else word_idx+1 and -> WAIT_BYTE.
REQ-022 FINISH: done=1 for exactly 1 cycle, then -> IDLE; no extra bytes accepted.
REQ-023 Outside DRIVE_ADDR/DRIVE_DATA, bus_load SHALL be 0 and bus_data SHALL be 8'h00.
REQ-024 cpu_rst_n SHALL be 0 in WAIT_BYTE..GAP and 1 in IDLE and FINISH.
REQ-025 Phase counter SHALL count 0..HOLD-1 and reload 0 on every phase entry; no wrap beyond HOLD-1.
REQ-026 word_idx SHALL never exceed WORDS-1; 4-bit value, no wrap within a session.
REQ-027 abort=1 in any non-IDLE state -> IDLE next cycle, done stays 0, bus_load 0, cpu_rst_n 1; abort in IDLE ignored.
REQ-028 abort has priority over start, byte handshake and phase/word advance in the same cycle.
REQ-029 start while busy SHALL be ignored.
REQ-030 Per-word latency from accepted byte to next byte_ready SHALL be 2*HOLD+2 cycles.

Reset
REQ-031 rst_n=0 at a clock edge -> IDLE, word_idx=0, phase counter=0, data register=0.
REQ-032 During/after reset: byte_ready=0, bus_data=0, bus_load=0, cpu_rst_n=1, busy=0, done=0.
REQ-033 Reset mid-session SHALL abandon the session without a done pulse; next start restarts at word 0.

Verification
REQ-034 Full load, HOLD=4, WORDS=16, bytes 0x10..0x1F always valid -> per word: 4 cycles bus_data=0x0i, 4 cycles 0x1i, 1 gap; done pulse once; cpu_rst_n high at FINISH; 160 cycles from first accept to FINISH.
REQ-035 Stalled source: byte_valid low 7 cycles at word 3 -> WAIT_BYTE held, byte_ready=1, bus_load=0, cpu_rst_n=0 throughout; resumes correctly.
REQ-036 Abort during DRIVE_DATA of word 5 -> next cycle IDLE, bus_load=0, cpu_rst_n=1, done never pulses.
REQ-037 rst_n low for 1 cycle during DRIVE_ADDR of word 2 -> all outputs at reset values; subsequent start loads from word_idx 0.
REQ-038 start pulsed while busy and start+abort same cycle in WAIT_BYTE -> start ignored, abort wins, FSM in IDLE.
REQ-039 WORDS=1, HOLD=2, byte 0xA5 -> bus_data 0x00,0x00,0xA5,0xA5, gap, done; word_idx stays 0.

Source files
------------

// File: rtl/cpu_program_loader_if.sv
// ---------------------------------------------------------------------------
// cpu_program_loader_if
//   Groups the byte-stream handshake from the host and the bus that the
//   loader drives toward the CPU pins.
//
//   byte_in    [7:0]  next program byte from the host source
//   byte_valid        byte_in holds a valid byte
//   byte_ready        loader takes byte_in this cycle
//   bus_data   [7:0]  value presented on the CPU ui_in pins
//   bus_load          load strobe on CPU uio_in[0]; high = bus_data owns bus
//
//   master : the loader (consumes bytes, drives the CPU bus)
//   slave  : the host / environment side
// ---------------------------------------------------------------------------
interface cpu_program_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] bus_data;
  logic       bus_load;

  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output bus_data,
    output bus_load
  );

  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  bus_data,
    input  bus_load
  );
endinterface

// File: rtl/cpu_program_loader.sv
// ---------------------------------------------------------------------------
// cpu_program_loader
//   Streams WORDS program bytes from a host into the CPU's RAM. For each
//   word the loader holds the CPU in reset, takes one byte, drives the word
//   address on the bus for HOLD cycles, then the byte for HOLD cycles,
//   then releases the bus for one gap cycle. A one-cycle done pulse marks
//   a completed session; abort or reset abandons it silently.
//
//   Parameters
//     WORDS  words per session (1..16)
//     HOLD   cycles each address/data phase is held (>=2)
//
//   Ports
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     start      begin a session (only honoured when idle)
//     abort      cancel the session from any busy state
//     lif        byte handshake + CPU bus (master modport)
//     cpu_rst_n  low while the CPU is held for loading
//     busy       high in every state except idle
//     done       one-cycle pulse on successful completion
//     word_idx   address of the word being loaded
// ---------------------------------------------------------------------------
module cpu_program_loader #(
  parameter int WORDS = 16,
  parameter int HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  cpu_program_loader_if.master lif,
  output logic                 cpu_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           word_idx
);

  localparam int            PW         = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(HOLD - 1);
  localparam logic [3:0]    WORD_LAST  = 4'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    DRIVE_ADDR,
    DRIVE_DATA,
    GAP,
    FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    word_q,  word_d;
  logic [7:0]    data_q,  data_d;

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      word_q  <= 4'd0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      word_q  <= word_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic. The abort override sits last so it beats start,
  // the byte handshake and any phase/word advance decided above.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    word_d  = word_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_BYTE;
          word_d  = 4'd0;
          phase_d = '0;
        end
      end

      WAIT_BYTE: begin
        if (lif.byte_valid) begin
          data_d  = lif.byte_in;
          state_d = DRIVE_ADDR;
          phase_d = '0;
        end
      end

      DRIVE_ADDR: begin
        if (phase_q == PHASE_LAST) begin
          state_d = DRIVE_DATA;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      DRIVE_DATA: begin
        if (phase_q == PHASE_LAST) begin
          state_d = GAP;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      // The last word stops the index at WORDS-1 instead of wrapping.
      GAP: begin
        phase_d = '0;
        if (word_q == WORD_LAST) begin
          state_d = FINISH;
        end else begin
          word_d  = word_q + 4'd1;
          state_d = WAIT_BYTE;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      phase_d = '0;
    end
  end

  // Moore outputs decoded purely from registered state and counters.
  always_comb begin
    lif.bus_data = 8'h00;
    lif.bus_load = 1'b0;
    case (state_q)
      DRIVE_ADDR: begin
        lif.bus_data = {4'b0000, word_q};
        lif.bus_load = 1'b1;
      end
      DRIVE_DATA: begin
        lif.bus_data = data_q;
        lif.bus_load = 1'b1;
      end
      default: begin
        lif.bus_data = 8'h00;
        lif.bus_load = 1'b0;
      end
    endcase
  end

  assign lif.byte_ready = (state_q == WAIT_BYTE);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FINISH);
  assign word_idx       = word_q;

  // The CPU is only released when no session is actively loading.
  assign cpu_rst_n = (state_q == IDLE) || (state_q == FINISH);

endmodule

// File: tb/tb_cpu_program_loader.sv
// ---------------------------------------------------------------------------
// tb_cpu_program_loader
//   Scoreboard bench for cpu_program_loader. Stimulus pushes the expected
//   bus beats and done-pulse timing into queues; a monitor pops and compares
//   whenever the loader drives the bus or pulses done. A second small
//   instance (WORDS=1, HOLD=2) covers the single-word case.
// ---------------------------------------------------------------------------
module tb_cpu_program_loader;

  localparam int HOLD  = 4;
  localparam int WORDS = 16;
  localparam int WORD_CYCLES = 2 * HOLD + 2;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] idx;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       cpuRstN;
  logic       busy;
  logic       done;
  logic [3:0] wordIdx;

  logic       start2;
  logic       abort2;
  logic       cpuRstN2;
  logic       busy2;
  logic       done2;
  logic [3:0] wordIdx2;

  int    checks     = 0;
  int    fails      = 0;
  int    cycleCount = 0;
  int    lastAccept = 0;
  beat_t expQ[$];
  int    doneQ[$];

  cpu_program_loader_if lif ();
  cpu_program_loader_if lif2 ();

  cpu_program_loader #(.WORDS(WORDS), .HOLD(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .lif       (lif),
    .cpu_rst_n (cpuRstN),
    .busy      (busy),
    .done      (done),
    .word_idx  (wordIdx)
  );

  cpu_program_loader #(.WORDS(1), .HOLD(2)) dutSmall (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .abort     (abort2),
    .lif       (lif2),
    .cpu_rst_n (cpuRstN2),
    .busy      (busy2),
    .done      (done2),
    .word_idx  (wordIdx2)
  );

  // Free-running clock and cycle counter used for latency bookkeeping.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic v, input logic [7:0] d);
    start          = s;
    abort          = a;
    lif.byte_valid = v;
    lif.byte_in    = d;
  endtask

  // Monitor: every bus beat must match the head of the expected queue, and
  // every done pulse must land on the cycle the stimulus predicted.
  always @(negedge clk) begin : monitor
    beat_t b;
    int    expCycle;
    if (lif.bus_load) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_beat: got bus_data %0h, expected no beat", lif.bus_data);
      end else begin
        b = expQ.pop_front();
        checkOutput("beat_data", lif.bus_data, b.data);
        checkOutput("beat_word_idx", wordIdx, b.idx);
        checkOutput("beat_cpu_rst_n", cpuRstN, 1'b0);
      end
    end else begin
      checkOutput("idle_bus_data", lif.bus_data, 8'h00);
    end
    if (done) begin
      if (doneQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done 1, expected 0");
      end else begin
        expCycle = doneQ.pop_front();
        checkOutput("done_cycle", cycleCount, expCycle);
        checkOutput("done_cpu_rst_n", cpuRstN, 1'b1);
      end
    end
  end

  // Waits (bounded) for the loader to request a byte; ends on that negedge.
  task automatic waitReady();
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!lif.byte_ready && waited < 60);
    checkOutput("byte_ready_seen", lif.byte_ready, 1'b1);
  endtask

  // Hands one byte over after an optional stall and queues the beats that
  // should follow; nBeats is shortened when the word will be cut off.
  task automatic sendByte(input logic [7:0] b, input logic [3:0] idx, input int stall,
                          input int nBeats, input bit checkLat, output int acc);
    beat_t bt;
    waitReady();
    for (int s = 0; s < stall; s++) begin
      checkOutput("stall_byte_ready", lif.byte_ready, 1'b1);
      checkOutput("stall_bus_load", lif.bus_load, 1'b0);
      checkOutput("stall_cpu_rst_n", cpuRstN, 1'b0);
      @(negedge clk);
    end
    acc = cycleCount;
    if (checkLat) checkOutput("word_latency", acc - lastAccept, WORD_CYCLES + stall);
    lastAccept = acc;
    applyStimulus(1'b0, 1'b0, 1'b1, b);
    for (int i = 0; i < nBeats; i++) begin
      bt.data = (i < HOLD) ? {4'h0, idx} : b;
      bt.idx  = idx;
      expQ.push_back(bt);
    end
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic pulseStart();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Full session of WORDS bytes 0x10+i, with an optional stall at one word.
  task automatic runSession(input int stallWord, input int stallLen);
    int acc;
    int waited;
    pulseStart();
    for (int w = 0; w < WORDS; w++) begin
      sendByte(8'(16 + w), 4'(w), (w == stallWord) ? stallLen : 0, 2 * HOLD, w != 0, acc);
      if (w == 0) doneQ.push_back(acc + WORDS * WORD_CYCLES + stallLen);
    end
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (busy && waited < 40);
    checkOutput("session_end_busy", busy, 1'b0);
    checkOutput("session_beats_left", expQ.size(), 0);
    checkOutput("session_done_left", doneQ.size(), 0);
  endtask

  // Global time limit so a stuck design still reaches the summary line.
  initial begin
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    int acc;
    logic [7:0] expData [7];
    logic       expLoad [7];
    logic       expRstN [7];
    logic       expDone [7];
    int         waited;

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    start2          = 1'b0;
    abort2          = 1'b0;
    lif2.byte_valid = 1'b0;
    lif2.byte_in    = 8'h00;
    rst_n           = 1'b0;

    // Reset values while rst_n is held low.
    repeat (2) @(negedge clk);
    checkOutput("rst_byte_ready", lif.byte_ready, 1'b0);
    checkOutput("rst_bus_data", lif.bus_data, 8'h00);
    checkOutput("rst_bus_load", lif.bus_load, 1'b0);
    checkOutput("rst_cpu_rst_n", cpuRstN, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_word_idx", wordIdx, 4'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Abort while idle has no effect.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("idle_abort_busy", busy, 1'b0);

    $display("[TB] full load, always-valid source");
    runSession(-1, 0);

    $display("[TB] full load, 7-cycle stall at word 3");
    runSession(3, 7);

    $display("[TB] abort during data phase of word 5");
    pulseStart();
    for (int w = 0; w < 5; w++) sendByte(8'(16 + w), 4'(w), 0, 2 * HOLD, w != 0, acc);
    sendByte(8'h15, 4'd5, 0, HOLD + 2, 1'b1, acc);
    while (cycleCount < acc + HOLD + 2) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_bus_load", lif.bus_load, 1'b0);
    checkOutput("abort_cpu_rst_n", cpuRstN, 1'b1);
    checkOutput("abort_done", done, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("abort_beats_left", expQ.size(), 0);

    $display("[TB] reset during address phase of word 2");
    pulseStart();
    for (int w = 0; w < 2; w++) sendByte(8'(16 + w), 4'(w), 0, 2 * HOLD, w != 0, acc);
    sendByte(8'h12, 4'd2, 0, 2, 1'b1, acc);
    while (cycleCount < acc + 2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_bus_load", lif.bus_load, 1'b0);
    checkOutput("midrst_cpu_rst_n", cpuRstN, 1'b1);
    checkOutput("midrst_word_idx", wordIdx, 4'd0);
    checkOutput("midrst_byte_ready", lif.byte_ready, 1'b0);
    checkOutput("midrst_beats_left", expQ.size(), 0);

    $display("[TB] restart after reset, start while busy, start+abort");
    pulseStart();
    sendByte(8'h77, 4'd0, 0, 2 * HOLD, 1'b0, acc);
    pulseStart();
    waitReady();
    checkOutput("restart_latency", cycleCount - acc, WORD_CYCLES);
    checkOutput("restart_word_idx", wordIdx, 4'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("startabort_busy", busy, 1'b0);
    checkOutput("startabort_byte_ready", lif.byte_ready, 1'b0);
    checkOutput("startabort_cpu_rst_n", cpuRstN, 1'b1);
    @(negedge clk);
    checkOutput("startabort_still_idle", busy, 1'b0);

    $display("[TB] single word, HOLD=2, byte A5");
    expData = '{8'h00, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00};
    expLoad = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    expRstN = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    expDone = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!lif2.byte_ready && waited < 20);
    checkOutput("small_byte_ready", lif2.byte_ready, 1'b1);
    lif2.byte_valid = 1'b1;
    lif2.byte_in    = 8'hA5;
    @(posedge clk);
    #1 lif2.byte_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput($sformatf("small_bus_data_%0d", i), lif2.bus_data, expData[i]);
      checkOutput($sformatf("small_bus_load_%0d", i), lif2.bus_load, expLoad[i]);
      checkOutput($sformatf("small_cpu_rst_n_%0d", i), cpuRstN2, expRstN[i]);
      checkOutput($sformatf("small_done_%0d", i), done2, expDone[i]);
      checkOutput($sformatf("small_word_idx_%0d", i), wordIdx2, 4'd0);
    end
    checkOutput("small_busy_end", busy2, 1'b0);

    checkOutput("final_beats_left", expQ.size(), 0);
    checkOutput("final_done_left", doneQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
